// File: rtl/fpu_iter_div_sqrt.sv
// Radix-2 iterative mantissa engine for binary32 divide / square root.
// Classifies and pre-normalizes operands, then produces one quotient/root bit per cycle.
module fpu_iter_div_sqrt #(
    parameter int C_DIV_EXP  = 8,
    parameter int C_DIV_MANT = 23,
    parameter int C_DIV_RM   = 2,
    parameter int C_ITER     = 28,
    localparam int C_DIV_MANT_PRENORM = C_DIV_MANT + 1
) (
    input  logic                          Clk_CI,
    input  logic                          Rst_RI,
    input  logic                          Start_SI,
    input  logic                          Kill_SI,
    input  logic                          Div_start_SI,
    input  logic [31:0]                   Operand_a_DI,
    input  logic [31:0]                   Operand_b_DI,
    input  logic [C_DIV_RM-1:0]           RM_SI,
    output logic                          Ready_SO,
    output logic                          Done_SO,
    output logic [C_DIV_MANT_PRENORM-1:0] Mant_DO,
    output logic [3:0]                    Round_bit_DO,
    output logic [C_DIV_EXP+1:0]          Exp_DO,
    output logic                          Sign_DO,
    output logic                          Div_enable_SO,
    output logic                          Sqrt_enable_SO,
    output logic                          Inf_a_SO,
    output logic                          Inf_b_SO,
    output logic                          Zero_a_SO,
    output logic                          Zero_b_SO,
    output logic                          NaN_a_SO,
    output logic                          NaN_b_SO,
    output logic [C_DIV_RM-1:0]           RM_SO
);

    localparam int C_EW = C_DIV_EXP + 2;
    localparam logic signed [C_EW-1:0] C_BIAS    = C_EW'(127);
    localparam logic signed [C_EW-1:0] C_BIAS_M1 = C_EW'(126);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

    state_t r_state, w_state_next;

    logic [31:0]                   r_op_a, r_op_b;
    logic                          r_is_div, r_sign;
    logic [C_DIV_RM-1:0]           r_rm;
    logic [5:0]                    r_flags;   // {inf_a, inf_b, zero_a, zero_b, nan_a, nan_b}
    logic [31:0]                   r_rem;
    logic [23:0]                   r_div;
    logic [55:0]                   r_rad;
    logic [27:0]                   r_q;
    logic [4:0]                    r_cnt;
    logic signed [C_EW-1:0]        r_exp_w;

    logic [C_DIV_MANT_PRENORM-1:0] r_mant;
    logic [3:0]                    r_round;
    logic [C_EW-1:0]               r_exp;
    logic                          r_sign_o, r_div_en, r_sqrt_en;
    logic [5:0]                    r_flags_o;
    logic [C_DIV_RM-1:0]           r_rm_o;

    function automatic logic [4:0] lzc24(input logic [23:0] m);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && m[i]) begin
                n     = 5'(23 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    // Operand classification at start; b is meaningless for sqrt so its flags stay clear.
    logic       w_a_ones, w_a_fnz, w_a_zexp, w_b_ones, w_b_fnz, w_b_zexp;
    logic [5:0] w_flags_in;
    logic       w_start_acc;

    assign w_a_ones   = &Operand_a_DI[30:23];
    assign w_a_fnz    = |Operand_a_DI[22:0];
    assign w_a_zexp   = ~|Operand_a_DI[30:23];
    assign w_b_ones   = &Operand_b_DI[30:23];
    assign w_b_fnz    = |Operand_b_DI[22:0];
    assign w_b_zexp   = ~|Operand_b_DI[30:23];
    assign w_flags_in = {w_a_ones & ~w_a_fnz,
                         Div_start_SI & w_b_ones & ~w_b_fnz,
                         w_a_zexp & ~w_a_fnz,
                         Div_start_SI & w_b_zexp & ~w_b_fnz,
                         w_a_ones & w_a_fnz,
                         Div_start_SI & w_b_ones & w_b_fnz};
    assign w_start_acc = Start_SI && (r_state == S_IDLE) && !Kill_SI;

    // Pre-normalization of both mantissas and exponent preparation.
    logic                   w_hid_a, w_hid_b;
    logic [23:0]            w_man_a, w_man_b, w_ma, w_mb;
    logic [4:0]             w_lz_a, w_lz_b;
    logic [C_EW-1:0]        w_eeff_a, w_eeff_b;
    logic signed [C_EW-1:0] w_ea, w_eb, w_exp_div, w_ea_bias, w_exp_sqrt;
    logic [24:0]            w_radicand;
    logic                   w_special;

    assign w_hid_a    = |r_op_a[30:23];
    assign w_hid_b    = |r_op_b[30:23];
    assign w_man_a    = {w_hid_a, r_op_a[22:0]};
    assign w_man_b    = {w_hid_b, r_op_b[22:0]};
    assign w_lz_a     = lzc24(w_man_a);
    assign w_lz_b     = lzc24(w_man_b);
    assign w_ma       = w_man_a << w_lz_a;
    assign w_mb       = w_man_b << w_lz_b;
    assign w_eeff_a   = w_hid_a ? C_EW'(r_op_a[30:23]) : C_EW'(1);
    assign w_eeff_b   = w_hid_b ? C_EW'(r_op_b[30:23]) : C_EW'(1);
    assign w_ea       = $signed(w_eeff_a - C_EW'(w_lz_a));
    assign w_eb       = $signed(w_eeff_b - C_EW'(w_lz_b));
    assign w_exp_div  = w_ea - w_eb + C_BIAS;
    assign w_ea_bias  = w_ea + (w_ea[0] ? C_BIAS : C_BIAS_M1);
    assign w_exp_sqrt = w_ea_bias >>> 1;
    assign w_radicand = w_ea[0] ? {1'b0, w_ma} : {w_ma, 1'b0};
    assign w_special  = (|r_flags) | (!r_is_div & r_op_a[31]);

    // Shared restoring step: divide compares against the divisor, sqrt against (root<<2)|1.
    logic [31:0] w_acc, w_trial, w_sub, w_rem_next;
    logic        w_ge, w_sticky;
    logic [27:0] w_q_next;

    always_comb begin
        w_acc   = r_rem;
        w_trial = {8'd0, r_div};
        if (!r_is_div) begin
            w_acc   = {r_rem[29:0], r_rad[55:54]};
            w_trial = {2'b00, r_q, 2'b01};
        end
        w_ge       = (w_acc >= w_trial);
        w_sub      = w_ge ? (w_acc - w_trial) : w_acc;
        w_rem_next = r_is_div ? (w_sub << 1) : w_sub;
    end

    assign w_q_next = {r_q[26:0], w_ge};
    assign w_sticky = |w_sub;

    logic w_last, w_load_out;
    assign w_last     = (r_state == S_ITER) && (r_cnt == 5'(C_ITER - 1));
    assign w_load_out = !Kill_SI && (((r_state == S_PRE) && w_special) || w_last);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_start_acc) w_state_next = S_PRE;
            S_PRE: begin
                if (Kill_SI)        w_state_next = S_IDLE;
                else if (w_special) w_state_next = S_DONE;
                else                w_state_next = S_ITER;
            end
            S_ITER: begin
                if (Kill_SI)     w_state_next = S_IDLE;
                else if (w_last) w_state_next = S_DONE;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_is_div  <= 1'b0;
            r_sign    <= 1'b0;
            r_rm      <= '0;
            r_flags   <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_rad     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_exp_w   <= '0;
            r_mant    <= '0;
            r_round   <= '0;
            r_exp     <= '0;
            r_sign_o  <= 1'b0;
            r_div_en  <= 1'b0;
            r_sqrt_en <= 1'b0;
            r_flags_o <= '0;
            r_rm_o    <= '0;
        end else begin
            if (w_start_acc) begin
                r_op_a   <= Operand_a_DI;
                r_op_b   <= Operand_b_DI;
                r_is_div <= Div_start_SI;
                r_rm     <= RM_SI;
                r_flags  <= w_flags_in;
                r_sign   <= Div_start_SI ? (Operand_a_DI[31] ^ Operand_b_DI[31]) : Operand_a_DI[31];
            end
            if ((r_state == S_PRE) && !Kill_SI) begin
                r_cnt   <= '0;
                r_q     <= '0;
                r_div   <= w_mb;
                r_rad   <= {w_radicand, 31'd0};
                r_rem   <= r_is_div ? {8'd0, w_ma} : 32'd0;
                r_exp_w <= r_is_div ? w_exp_div : w_exp_sqrt;
            end
            if ((r_state == S_ITER) && !Kill_SI) begin
                r_q   <= w_q_next;
                r_rem <= w_rem_next;
                r_rad <= r_rad << 2;
                r_cnt <= r_cnt + 5'd1;
            end
            // Result registers change only when an operation actually completes.
            if (w_load_out) begin
                r_sign_o  <= r_sign;
                r_div_en  <= r_is_div;
                r_sqrt_en <= !r_is_div;
                r_flags_o <= r_flags;
                r_rm_o    <= r_rm;
                if (r_state == S_PRE) begin
                    r_mant  <= '0;
                    r_round <= '0;
                    r_exp   <= '0;
                end else begin
                    r_mant  <= w_q_next[27:4];
                    r_round <= {w_q_next[3:1], w_q_next[0] | w_sticky};
                    r_exp   <= r_exp_w;
                end
            end
        end
    end

    assign Ready_SO       = (r_state == S_IDLE);
    assign Done_SO        = (r_state == S_DONE);
    assign Mant_DO        = r_mant;
    assign Round_bit_DO   = r_round;
    assign Exp_DO         = r_exp;
    assign Sign_DO        = r_sign_o;
    assign Div_enable_SO  = r_div_en;
    assign Sqrt_enable_SO = r_sqrt_en;
    assign {Inf_a_SO, Inf_b_SO, Zero_a_SO, Zero_b_SO, NaN_a_SO, NaN_b_SO} = r_flags_o;
    assign RM_SO          = r_rm_o;

endmodule

// File: tb/tb_fpu_iter_div_sqrt.sv
// Table-driven bench for fpu_iter_div_sqrt: expected results are queued at start
// and compared when Done_SO fires; kill, busy-start and async reset are hand sequenced.
module tb_fpu_iter_div_sqrt;

    typedef struct {
        logic        div;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [23:0] mant;
        logic [3:0]  rnd;
        logic [9:0]  exp;
        logic        sign;
        logic [5:0]  flags;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic        div = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  rm = '0;

    logic        ready, done, sign, div_en, sqrt_en;
    logic        inf_a, inf_b, zero_a, zero_b, nan_a, nan_b;
    logic [23:0] mant;
    logic [3:0]  rnd;
    logic [9:0]  expo;
    logic [1:0]  rm_o;

    fpu_iter_div_sqrt dut (
        .Clk_CI(clk), .Rst_RI(rst), .Start_SI(start), .Kill_SI(kill),
        .Div_start_SI(div), .Operand_a_DI(a), .Operand_b_DI(b), .RM_SI(rm),
        .Ready_SO(ready), .Done_SO(done), .Mant_DO(mant), .Round_bit_DO(rnd),
        .Exp_DO(expo), .Sign_DO(sign), .Div_enable_SO(div_en), .Sqrt_enable_SO(sqrt_en),
        .Inf_a_SO(inf_a), .Inf_b_SO(inf_b), .Zero_a_SO(zero_a), .Zero_b_SO(zero_b),
        .NaN_a_SO(nan_a), .NaN_b_SO(nan_b), .RM_SO(rm_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    vec_t exp_q[$];
    int   acc_q[$];
    vec_t tbl[15];
    vec_t m_e;
    int   m_acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic d, input logic [31:0] a_i, input logic [31:0] b_i,
                                input logic [1:0] rm_i, input logic [23:0] m, input logic [3:0] r,
                                input logic [9:0] e, input logic s, input logic [5:0] f, input int l);
        vec_t v;
        v.div = d; v.a = a_i; v.b = b_i; v.rm = rm_i; v.mant = m; v.rnd = r;
        v.exp = e; v.sign = s; v.flags = f; v.lat = l;
        return v;
    endfunction

    // Scoreboard monitor: one line per completed transaction.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got Done_SO=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                m_e   = exp_q.pop_front();
                m_acc = acc_q.pop_front();
                $display("txn %s a=%08h b=%08h rm=%0d -> mant=%06h rnd=%h exp=%0d sign=%0d flags=%06b lat=%0d",
                         m_e.div ? "div " : "sqrt", m_e.a, m_e.b, m_e.rm, mant, rnd, $signed(expo), sign,
                         {inf_a, inf_b, zero_a, zero_b, nan_a, nan_b}, cyc - m_acc + 1);
                chk("latency", 32'(cyc - m_acc + 1), 32'(m_e.lat));
                chk("mant", 32'(mant), 32'(m_e.mant));
                chk("round", 32'(rnd), 32'(m_e.rnd));
                chk("exp", 32'(expo), 32'(m_e.exp));
                chk("sign", 32'(sign), 32'(m_e.sign));
                chk("flags", 32'({inf_a, inf_b, zero_a, zero_b, nan_a, nan_b}), 32'(m_e.flags));
                chk("enables", 32'({div_en, sqrt_en}), 32'({m_e.div, ~m_e.div}));
                chk("rm", 32'(rm_o), 32'(m_e.rm));
            end
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ready) chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic drive_start(input vec_t v);
        div = v.div; a = v.a; b = v.b; rm = v.rm; start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(v);
        acc_q.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int d0;
        wait_ready();
        d0 = done_cnt;
        drive_start(v);
        wait_done(d0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        tbl[0]  = mk(1'b1, 32'h3FC00000, 32'h3F800000, 2'd0, 24'hC00000, 4'h0, 10'd127, 1'b0, 6'b000000, 30);
        tbl[1]  = mk(1'b1, 32'h3F800000, 32'h40400000, 2'd3, 24'h555555, 4'h5, 10'd126, 1'b0, 6'b000000, 30);
        tbl[2]  = mk(1'b0, 32'h40800000, 32'h00000000, 2'd1, 24'h800000, 4'h0, 10'd128, 1'b0, 6'b000000, 30);
        tbl[3]  = mk(1'b0, 32'h40000000, 32'h7FC00000, 2'd2, 24'hB504F3, 4'h3, 10'd127, 1'b0, 6'b000000, 30);
        tbl[4]  = mk(1'b1, 32'h00000001, 32'h7F000000, 2'd0, 24'h800000, 4'h0, 10'h36B, 1'b0, 6'b000000, 30);
        tbl[5]  = mk(1'b1, 32'h7FC00000, 32'h3F800000, 2'd1, 24'h000000, 4'h0, 10'd0,   1'b0, 6'b000010, 2);
        tbl[6]  = mk(1'b0, 32'hBF800000, 32'h00000000, 2'd2, 24'h000000, 4'h0, 10'd0,   1'b1, 6'b000000, 2);
        tbl[7]  = mk(1'b1, 32'hC0000000, 32'h00000000, 2'd3, 24'h000000, 4'h0, 10'd0,   1'b1, 6'b000100, 2);
        tbl[8]  = mk(1'b1, 32'h7F800000, 32'hFF800000, 2'd0, 24'h000000, 4'h0, 10'd0,   1'b1, 6'b110000, 2);
        tbl[9]  = mk(1'b1, 32'hBF800000, 32'h3FC00000, 2'd1, 24'h555555, 4'h5, 10'd127, 1'b1, 6'b000000, 30);
        tbl[10] = mk(1'b1, 32'h7F7FFFFF, 32'h3F800000, 2'd2, 24'hFFFFFF, 4'h0, 10'd254, 1'b0, 6'b000000, 30);
        tbl[11] = mk(1'b0, 32'h00000001, 32'h00000000, 2'd3, 24'hB504F3, 4'h3, 10'd52,  1'b0, 6'b000000, 30);
        tbl[12] = mk(1'b1, 32'h3F800000, 32'h00800000, 2'd0, 24'h800000, 4'h0, 10'd253, 1'b0, 6'b000000, 30);
        tbl[13] = mk(1'b0, 32'h3F800000, 32'h00000000, 2'd1, 24'h800000, 4'h0, 10'd127, 1'b0, 6'b000000, 30);
        tbl[14] = mk(1'b0, 32'h7F800000, 32'h00000000, 2'd2, 24'h000000, 4'h0, 10'd0,   1'b0, 6'b100000, 2);

        #1 rst = 1'b1;
        #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_data", 32'({mant, rnd}), 32'd0);
        chk("reset_exp_rm", 32'({expo, rm_o}), 32'd0);
        chk("reset_flags", 32'({sign, div_en, sqrt_en, inf_a, inf_b, zero_a, zero_b, nan_a, nan_b}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) run_vec(tbl[i]);

        // Start while busy must be ignored and must not disturb the running operation.
        wait_ready();
        d0 = done_cnt;
        drive_start(tbl[1]);
        repeat (4) @(negedge clk);
        div = 1'b1; a = 32'h7FC00000; b = 32'h3F800000; start = 1'b1;
        chk("busy_ready", 32'(ready), 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done(d0);

        // Kill sampled at the end of cycle 10: idle in cycle 11, previous result held.
        wait_ready();
        div = 1'b1; a = 32'h3FC00000; b = 32'h3F800000; rm = 2'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        chk("kill_ready", 32'(ready), 32'd1);
        chk("kill_no_done", 32'(done), 32'd0);
        chk("kill_mant_held", 32'(mant), 32'h555555);
        chk("kill_exp_held", 32'({expo, rnd, rm_o}), 32'({10'd126, 4'h5, 2'd3}));
        @(negedge clk);
        kill = 1'b0;
        repeat (40) @(negedge clk);
        run_vec(tbl[0]);

        // Asynchronous reset in cycle 15 of a running operation.
        run_vec(tbl[9]);
        wait_ready();
        div = 1'b1; a = 32'h3F800000; b = 32'h40400000; rm = 2'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (13) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("areset_ready", 32'(ready), 32'd1);
        chk("areset_done", 32'(done), 32'd0);
        chk("areset_data", 32'({mant, rnd}), 32'd0);
        chk("areset_exp_rm", 32'({expo, rm_o}), 32'd0);
        chk("areset_flags", 32'({sign, div_en, sqrt_en, inf_a, inf_b, zero_a, zero_b, nan_a, nan_b}), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_vec(tbl[3]);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
